// File: rtl/swap_pkg.sv
// Shared constants, bus-source encoding and source-priority helper for the swap datapath.
package swap_pkg;

    localparam int unsigned SWAP_WIDTH = 8;
    localparam int unsigned XFER_W     = 8;
    localparam logic [XFER_W-1:0] XFER_MAX = XFER_W'(255);

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_EXT  = 3'd1,
        SRC_R1   = 3'd2,
        SRC_R2   = 3'd3,
        SRC_R3   = 3'd4
    } bus_src_e;

    // Fixed priority: Extern > R1out > R2out > R3out.
    function automatic bus_src_e pick_src(input logic ext, input logic r1o,
                                          input logic r2o, input logic r3o);
        bus_src_e s;
        if (ext)      s = SRC_EXT;
        else if (r1o) s = SRC_R1;
        else if (r2o) s = SRC_R2;
        else if (r3o) s = SRC_R3;
        else          s = SRC_NONE;
        return s;
    endfunction

endpackage

// File: rtl/swap_datapath_if.sv
// Strobe/handshake bundle between the swap controller/consumer (master) and the datapath (slave).
interface swap_datapath_if
    import swap_pkg::*;
#(
    parameter int unsigned N = SWAP_WIDTH
);
    logic [N-1:0]      Data;
    logic              Extern;
    logic              R1in, R2in, R3in;
    logic              R1out, R2out, R3out;
    logic              Done;
    logic              Ack;
    logic [N-1:0]      BusWires;
    logic [N-1:0]      Result1, Result2;
    logic              Valid;
    logic              Overrun;
    logic              Conflict;
    logic [XFER_W-1:0] XferCount;

    modport master (
        output Data, Extern, R1in, R2in, R3in, R1out, R2out, R3out, Done, Ack,
        input  BusWires, Result1, Result2, Valid, Overrun, Conflict, XferCount
    );

    modport slave (
        input  Data, Extern, R1in, R2in, R3in, R1out, R2out, R3out, Done, Ack,
        output BusWires, Result1, Result2, Valid, Overrun, Conflict, XferCount
    );

endinterface

// File: rtl/regn.sv
// N-bit register with load enable and asynchronous active-low clear.
module regn #(
    parameter int unsigned N = 8
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         ld,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)  q <= '0;
        else if (ld)  q <= d;
    end

endmodule

// File: rtl/swap_datapath.sv
// Three-register shared-bus datapath executing swap-controller strobes, with Valid/Ack result handshake.
// Optional conflict detection is enabled by defining SWAP_DATAPATH_CONFLICT_CHECK_EN.
module swap_datapath
    import swap_pkg::*;
#(
    parameter int unsigned N = SWAP_WIDTH
) (
    input  logic           Clock,
    input  logic           Resetn,
    swap_datapath_if.slave sw
);

    bus_src_e          src;
    logic [N-1:0]      bus_c;
    logic [N-1:0]      r1_q, r2_q, r3_q;
    logic [N-1:0]      r1_next, r2_next;
    logic              any_load;
    logic [N-1:0]      res1_q, res2_q;
    logic              valid_q;
    logic              overrun_q;
    logic              conflict_q;
    logic [XFER_W-1:0] xfer_q;

    // Bus mux: highest-priority active source, zero when idle.
    always_comb begin
        src   = pick_src(sw.Extern, sw.R1out, sw.R2out, sw.R3out);
        bus_c = '0;
        unique case (src)
            SRC_EXT:  bus_c = sw.Data;
            SRC_R1:   bus_c = r1_q;
            SRC_R2:   bus_c = r2_q;
            SRC_R3:   bus_c = r3_q;
            default:  bus_c = '0;
        endcase
    end

    regn #(.N(N)) u_r1 (.Clock(Clock), .Resetn(Resetn), .ld(sw.R1in), .d(bus_c), .q(r1_q));
    regn #(.N(N)) u_r2 (.Clock(Clock), .Resetn(Resetn), .ld(sw.R2in), .d(bus_c), .q(r2_q));
    regn #(.N(N)) u_r3 (.Clock(Clock), .Resetn(Resetn), .ld(sw.R3in), .d(bus_c), .q(r3_q));

    // Post-edge register values, so Done captures the final swap step.
    assign r1_next  = sw.R1in ? bus_c : r1_q;
    assign r2_next  = sw.R2in ? bus_c : r2_q;
    assign any_load = sw.R1in | sw.R2in | sw.R3in;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            xfer_q <= '0;
        end else if (any_load && (xfer_q != XFER_MAX)) begin
            xfer_q <= xfer_q + XFER_W'(1);
        end
    end

    // Result handshake: Done has priority over Ack in the same cycle.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            res1_q    <= '0;
            res2_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (sw.Done) begin
            res1_q  <= r1_next;
            res2_q  <= r2_next;
            valid_q <= 1'b1;
            if (valid_q && !sw.Ack) overrun_q <= 1'b1;
        end else if (sw.Ack) begin
            valid_q <= 1'b0;
        end
    end

`ifdef SWAP_DATAPATH_CONFLICT_CHECK_EN
    logic multi_src_c;

    assign multi_src_c = (sw.Extern & (sw.R1out | sw.R2out | sw.R3out))
                       | (sw.R1out  & (sw.R2out | sw.R3out))
                       | (sw.R2out  & sw.R3out);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)          conflict_q <= 1'b0;
        else if (multi_src_c) conflict_q <= 1'b1;
    end
`else
    assign conflict_q = 1'b0;
`endif

    assign sw.BusWires  = bus_c;
    assign sw.Result1   = res1_q;
    assign sw.Result2   = res2_q;
    assign sw.Valid     = valid_q;
    assign sw.Overrun   = overrun_q;
    assign sw.Conflict  = conflict_q;
    assign sw.XferCount = xfer_q;

endmodule

// File: tb/tb_swap_datapath.sv
// Directed self-checking bench for swap_datapath (conflict expectation follows SWAP_DATAPATH_CONFLICT_CHECK_EN).
module tb_swap_datapath;

    logic Clock;
    logic Resetn;
    int   passed;
    int   total;

    swap_datapath_if #(.N(8)) sw_if ();

    swap_datapath #(.N(8)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .sw     (sw_if)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

`ifdef SWAP_DATAPATH_CONFLICT_CHECK_EN
    localparam logic CONFLICT_EXP = 1'b1;
`else
    localparam logic CONFLICT_EXP = 1'b0;
`endif

    task automatic idle();
        sw_if.Data   = 8'h00;
        sw_if.Extern = 1'b0;
        sw_if.R1in   = 1'b0; sw_if.R2in  = 1'b0; sw_if.R3in  = 1'b0;
        sw_if.R1out  = 1'b0; sw_if.R2out = 1'b0; sw_if.R3out = 1'b0;
        sw_if.Done   = 1'b0;
        sw_if.Ack    = 1'b0;
    endtask

    // Advance one edge and settle; inputs are then cleared for the next cycle.
    task automatic step();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        Resetn = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Resetn = 1'b1;
    endtask

    task automatic load_ext(input logic [7:0] v, input int which);
        sw_if.Extern = 1'b1;
        sw_if.Data   = v;
        if (which == 1) sw_if.R1in = 1'b1;
        else            sw_if.R2in = 1'b1;
        step();
    endtask

    // Controller states B, C, D; ack_in_d asserts Ack together with Done.
    task automatic swap_seq(input logic ack_in_d);
        sw_if.R2out = 1'b1; sw_if.R3in = 1'b1; step();
        sw_if.R1out = 1'b1; sw_if.R2in = 1'b1; step();
        sw_if.R3out = 1'b1; sw_if.R1in = 1'b1; sw_if.Done = 1'b1;
        sw_if.Ack   = ack_in_d;
        step();
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        idle();
        #2;
        total++; if (sw_if.Valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", sw_if.Valid); else passed++;
        total++; if (sw_if.Result1 !== 8'h00 || sw_if.Result2 !== 8'h00)
                     $display("FAIL reset_results got=%h/%h exp=00/00", sw_if.Result1, sw_if.Result2); else passed++;
        total++; if (sw_if.XferCount !== 8'd0 || sw_if.Overrun !== 1'b0 || sw_if.Conflict !== 1'b0)
                     $display("FAIL reset_flags got cnt=%0d ovr=%b cfl=%b exp 0/0/0", sw_if.XferCount, sw_if.Overrun, sw_if.Conflict);
                 else passed++;
        total++; if (sw_if.BusWires !== 8'h00) $display("FAIL reset_bus got=%h exp=00", sw_if.BusWires); else passed++;
        @(posedge Clock); #1;
        Resetn = 1'b1;
    endtask

    task automatic test_load_swap();
        load_ext(8'h5A, 1);
        load_ext(8'hC3, 2);
        sw_if.R2out = 1'b1; sw_if.R3in = 1'b1;
        #1;
        total++; if (sw_if.BusWires !== 8'hC3) $display("FAIL swap_bus_stateB got=%h exp=c3", sw_if.BusWires); else passed++;
        step();
        sw_if.R1out = 1'b1; sw_if.R2in = 1'b1; step();
        sw_if.R3out = 1'b1; sw_if.R1in = 1'b1; sw_if.Done = 1'b1; step();
        total++; if (sw_if.Result1 !== 8'hC3 || sw_if.Result2 !== 8'h5A)
                     $display("FAIL swap_results got=%h/%h exp=c3/5a", sw_if.Result1, sw_if.Result2); else passed++;
        total++; if (sw_if.Valid !== 1'b1) $display("FAIL swap_valid got=%b exp=1", sw_if.Valid); else passed++;
        total++; if (sw_if.XferCount !== 8'd5) $display("FAIL swap_xfercount got=%0d exp=5", sw_if.XferCount); else passed++;
        sw_if.R3out = 1'b1; #1;
        total++; if (sw_if.BusWires !== 8'hC3) $display("FAIL swap_r3 got=%h exp=c3", sw_if.BusWires); else passed++;
        idle();
    endtask

    task automatic test_overrun();
        swap_seq(1'b0);
        total++; if (sw_if.Overrun !== 1'b1) $display("FAIL overrun_flag got=%b exp=1", sw_if.Overrun); else passed++;
        total++; if (sw_if.Result1 !== 8'h5A || sw_if.Result2 !== 8'hC3)
                     $display("FAIL overrun_results got=%h/%h exp=5a/c3", sw_if.Result1, sw_if.Result2); else passed++;
        total++; if (sw_if.XferCount !== 8'd8) $display("FAIL overrun_xfercount got=%0d exp=8", sw_if.XferCount); else passed++;
    endtask

    task automatic test_ack();
        sw_if.Ack = 1'b1; step();
        total++; if (sw_if.Valid !== 1'b0) $display("FAIL ack_valid got=%b exp=0", sw_if.Valid); else passed++;
        total++; if (sw_if.Result1 !== 8'h5A || sw_if.Result2 !== 8'hC3)
                     $display("FAIL ack_hold got=%h/%h exp=5a/c3", sw_if.Result1, sw_if.Result2); else passed++;
        step();
        total++; if (sw_if.Overrun !== 1'b1) $display("FAIL overrun_sticky got=%b exp=1", sw_if.Overrun); else passed++;
    endtask

    task automatic test_ack_done();
        do_reset();
        load_ext(8'h5A, 1);
        load_ext(8'hC3, 2);
        swap_seq(1'b0);
        swap_seq(1'b1);
        total++; if (sw_if.Valid !== 1'b1) $display("FAIL ackdone_valid got=%b exp=1", sw_if.Valid); else passed++;
        total++; if (sw_if.Overrun !== 1'b0) $display("FAIL ackdone_overrun got=%b exp=0", sw_if.Overrun); else passed++;
        total++; if (sw_if.Result1 !== 8'h5A || sw_if.Result2 !== 8'hC3)
                     $display("FAIL ackdone_results got=%h/%h exp=5a/c3", sw_if.Result1, sw_if.Result2); else passed++;
        sw_if.Ack = 1'b1; step();
        sw_if.Ack = 1'b1; step();
        total++; if (sw_if.Valid !== 1'b0 || sw_if.Overrun !== 1'b0)
                     $display("FAIL ackhold got valid=%b ovr=%b exp 0/0", sw_if.Valid, sw_if.Overrun); else passed++;
    endtask

    task automatic test_conflict();
        do_reset();
        load_ext(8'h77, 1);
        sw_if.R1out = 1'b1; sw_if.R3out = 1'b1; #1;
        total++; if (sw_if.BusWires !== 8'h77) $display("FAIL priority_r1_r3 got=%h exp=77", sw_if.BusWires); else passed++;
        idle();
        total++; if (sw_if.Conflict !== 1'b0) $display("FAIL conflict_pre got=%b exp=0", sw_if.Conflict); else passed++;
        sw_if.Extern = 1'b1; sw_if.R2out = 1'b1; sw_if.Data = 8'h11; sw_if.R3in = 1'b1; #1;
        total++; if (sw_if.BusWires !== 8'h11) $display("FAIL priority_ext got=%h exp=11", sw_if.BusWires); else passed++;
        step();
        total++; if (sw_if.Conflict !== CONFLICT_EXP) $display("FAIL conflict_flag got=%b exp=%b", sw_if.Conflict, CONFLICT_EXP); else passed++;
        sw_if.R3out = 1'b1; #1;
        total++; if (sw_if.BusWires !== 8'h11) $display("FAIL conflict_r3 got=%h exp=11", sw_if.BusWires); else passed++;
        idle();
        repeat (2) step();
        total++; if (sw_if.Conflict !== CONFLICT_EXP) $display("FAIL conflict_sticky got=%b exp=%b", sw_if.Conflict, CONFLICT_EXP); else passed++;
    endtask

    task automatic test_reset_mid_swap();
        do_reset();
        load_ext(8'h5A, 1);
        load_ext(8'hC3, 2);
        swap_seq(1'b0);
        sw_if.R2out = 1'b1; sw_if.R3in = 1'b1; step();
        sw_if.R1out = 1'b1; sw_if.R2in = 1'b1;
        #2;
        Resetn = 1'b0;
        #1;
        total++; if (sw_if.Valid !== 1'b0 || sw_if.Result1 !== 8'h00 || sw_if.Result2 !== 8'h00)
                     $display("FAIL midreset_results got v=%b %h/%h exp 0 00/00", sw_if.Valid, sw_if.Result1, sw_if.Result2);
                 else passed++;
        total++; if (sw_if.XferCount !== 8'd0) $display("FAIL midreset_xfercount got=%0d exp=0", sw_if.XferCount); else passed++;
        idle();
        sw_if.R1out = 1'b1; #1;
        total++; if (sw_if.BusWires !== 8'h00) $display("FAIL midreset_r1 got=%h exp=00", sw_if.BusWires); else passed++;
        sw_if.R1out = 1'b0; sw_if.R2out = 1'b1; #1;
        total++; if (sw_if.BusWires !== 8'h00) $display("FAIL midreset_r2 got=%h exp=00", sw_if.BusWires); else passed++;
        sw_if.R2out = 1'b0; sw_if.R3out = 1'b1; #1;
        total++; if (sw_if.BusWires !== 8'h00) $display("FAIL midreset_r3 got=%h exp=00", sw_if.BusWires); else passed++;
        idle();
        @(posedge Clock); #1;
        Resetn = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 254; i++) begin
            sw_if.Extern = 1'b1; sw_if.R1in = 1'b1; step();
        end
        total++; if (sw_if.XferCount !== 8'd254) $display("FAIL sat_254 got=%0d exp=254", sw_if.XferCount); else passed++;
        for (int i = 0; i < 46; i++) begin
            sw_if.Extern = 1'b1; sw_if.R1in = 1'b1; step();
        end
        total++; if (sw_if.XferCount !== 8'd255) $display("FAIL sat_300 got=%0d exp=255", sw_if.XferCount); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        Resetn = 1'b0;
        idle();
        test_reset();
        test_load_swap();
        test_overrun();
        test_ack();
        test_ack_done();
        test_conflict();
        test_reset_mid_swap();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/swap_datapath.md
# swap_datapath

Bus-based register datapath that executes the transfer commands issued by the three-register swap controller. It holds R1, R2 and R3 on a shared N-bit bus and loads the registers from that bus according to the controller's R1in…R3out strobes. On the controller's Done strobe it registers the swapped result and presents it through a Valid/Ack handshake. It is the responder side of the controller's strobe interface: the controller issues strobes and this block executes them.

## Interface

- N, 8, data and bus width in bits
- Clock  in  1  rising-edge clock
- Resetn  in  1  reset, asynchronous, active-low
- Data  in  N  external load value
- Extern  in  1  drive Data onto bus this cycle
- R1in, R2in, R3in  in  1 each  load register from bus at next edge
- R1out, R2out, R3out  in  1 each  drive register onto bus
- Done  in  1  controller completion strobe
- Ack  in  1  consumer accepts Result1/Result2
- BusWires  out  N  current bus value (combinational)
- Result1, Result2  out  N  captured R1, R2 after swap
- Valid  out  1  Result1/Result2 hold unconsumed data
- Overrun  out  1  sticky: Done arrived while Valid=1 and Ack=0
- Conflict  out  1  sticky: more than one bus source in one cycle
- XferCount  out  8  saturating count of load cycles

## Operation

- **Bus source selection:** fixed priority Extern > R1out > R2out > R3out. With no source active, the bus is all zeros.
- **Register loads:** each register whose Rxin=1 loads BusWires at the rising edge.
  - Multiple Rxin in one cycle is legal (broadcast).
  - A register may drive and load in the same cycle. It reloads its own value.
- **XferCount:** increments at each edge where any Rxin=1. It saturates at 255.
- **Done capture:** at an edge with Done=1:
  - Result1 <= value R1 holds after that edge (the bus value if R1in=1, else R1).
  - Result2 <= value R2 holds after that edge, computed the same way.
  - Valid <= 1.
- **Ack:** at an edge with Ack=1 and Done=0, Valid <= 0.
- **Ack and Done in the same cycle:** Done wins. Results are recaptured and Valid stays 1. Overrun is not set.
- **Overrun:** set when Done=1, Valid=1 and Ack=0. Results are overwritten anyway.
- **Sticky flags:** Overrun and Conflict clear only on reset.
- **Reset values:** R1=R2=R3=0, Result1=Result2=0, Valid=0, Overrun=0, Conflict=0, XferCount=0.
- **Reset mid-swap:** all of the above are forced immediately and asynchronously. No partial result is presented.

## Timing

- BusWires is combinational from the Rxout strobes, Extern and Data. Zero latency.
- Register contents update one cycle after the strobe cycle.
- Result and Valid are registered. Valid rises at the edge that samples Done.
- Controller sequence, one cycle per state (A→B→C→D):
  - State B drives R2out, R3in.
  - State C drives R1out, R2in.
  - State D drives R3out, R1in, Done.
  - Valid is high from the edge ending state D, with swapped values.
- Ack is sampled only at rising edges. The consumer may hold Ack high continuously.

## Configuration

- Macro: SWAP_DATAPATH_CONFLICT_CHECK_EN.
- **Defined:** Conflict sets at any edge where two or more of {Extern, R1out, R2out, R3out} are 1.
- **Undefined:** the conflict detection logic is absent and Conflict is tied to 0. Bus priority behaviour is identical in both builds.

## Structure

- **Package swap_pkg:**
  - default width constant (8)
  - bus-source enum: NONE, EXT, R1, R2, R3
  - XferCount width and saturation constant
- **Sub-module regn:** N-bit register with load enable and async active-low clear. Instantiated three times, for R1, R2 and R3.
- Bus mux, handshake, counters and flags live in swap_datapath.

## Test plan

- **Load then swap:** Extern loads R1=0x5A, then R2=0xC3; run the B/C/D strobe sequence.
  -> Result1=0xC3, Result2=0x5A, Valid=1, R3=0xC3, XferCount=5.
- **Ack:** Ack pulsed one cycle after Valid.
  -> Valid=0 at next edge; Result1/Result2 hold their values.
- **Overrun:** second swap completes with Valid still 1 and Ack=0.
  -> Overrun=1; results overwritten with re-swapped values 0x5A/0xC3.
- **Ack and Done together:** Ack=1 in the same cycle as Done.
  -> Valid stays 1, Overrun stays 0, new results captured.
- **Conflict (macro defined):** Extern=1 with R2out=1, Data=0x11, R3in=1.
  -> R3=0x11, Conflict=1.
  - Same stimulus with macro undefined -> Conflict=0.
- **Reset mid-swap:** Resetn low during state C.
  -> all registers, Result1/Result2, Valid and XferCount read 0 before the next edge.
  - XferCount saturation: 300 load cycles -> XferCount=255.
